// File: rtl/fetch_memory_port_pkg.sv
// rtl/fetch_memory_port_pkg.sv - shared register type, Nop encoding and fetch bridge state type
package fetch_memory_port_pkg;

  typedef logic [31:0] regval_t;

  // Canonical no-op (addi x0, x0, 0) returned whenever no instruction word is valid.
  localparam regval_t Nop = 32'h0000_0013;

  typedef enum logic [1:0] {
    Idle,
    Request,
    Wait,
    Discard
  } state_t;

endpackage

// File: rtl/fetch_memory_port.sv
// rtl/fetch_memory_port.sv - single-outstanding instruction bus read bridge for the fetch stage
module fetch_memory_port
  import fetch_memory_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  address_enable,
  input  regval_t               address,
  input  logic                  flush,
  output regval_t               data,
  output logic                  data_valid,
  output logic                  has_flushed,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_waitrequest,
  input  regval_t               mem_readdata,
  input  logic                  mem_readdatavalid
);

  state_t      state_q, state_d;
  logic        stale_q, stale_d;
  logic [31:2] req_address_q, req_address_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:2] buf_address_q, buf_address_d;
  regval_t     buf_data_q, buf_data_d;

  logic buf_hit;
  logic req_match;

  // Byte offset within the word never participates in any compare or bus address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[1:0];

  assign buf_hit   = buf_valid_q && address_enable && !flush
                     && (address[31:2] == buf_address_q);
  assign req_match = address_enable && !flush && (address[31:2] == req_address_q);

  always_comb begin
    state_d       = state_q;
    stale_d       = stale_q;
    req_address_d = req_address_q;
    buf_valid_d   = buf_valid_q;
    buf_address_d = buf_address_q;
    buf_data_d    = buf_data_q;
    mem_read      = 1'b0;
    data_valid    = 1'b0;
    data          = Nop;

    // One-shot buffer: consumed the cycle it is delivered.
    if (buf_hit) begin
      data_valid  = 1'b1;
      data        = buf_data_q;
      buf_valid_d = 1'b0;
    end

    unique case (state_q)
      Idle: begin
        if (address_enable && !flush && !buf_hit) begin
          req_address_d = address[31:2];
          state_d       = Request;
        end
      end
      Request: begin
        mem_read = 1'b1;
        if (flush) begin
          stale_d = 1'b1;
        end
        if (!mem_waitrequest) begin
          state_d = (stale_q || flush) ? Discard : Wait;
        end
      end
      Wait: begin
        if (mem_readdatavalid) begin
          state_d = Idle;
          if (!flush) begin
            if (req_match) begin
              data_valid = 1'b1;
              data       = mem_readdata;
            end else begin
              buf_valid_d   = 1'b1;
              buf_address_d = req_address_q;
              buf_data_d    = mem_readdata;
            end
          end
        end else if (flush) begin
          state_d = Discard;
        end
      end
      Discard: begin
        if (mem_readdatavalid) begin
          stale_d = 1'b0;
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase

    if (flush) begin
      buf_valid_d = 1'b0;
    end
  end

  assign mem_address = (state_q == Request) ? ADDR_WIDTH'({req_address_q, 2'b00})
                                            : '0;
  assign has_flushed = !flush && !stale_q && (state_q != Discard);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= Idle;
      stale_q       <= 1'b0;
      req_address_q <= '0;
      buf_valid_q   <= 1'b0;
      buf_address_q <= '0;
      buf_data_q    <= Nop;
    end else begin
      state_q       <= state_d;
      stale_q       <= stale_d;
      req_address_q <= req_address_d;
      buf_valid_q   <= buf_valid_d;
      buf_address_q <= buf_address_d;
      buf_data_q    <= buf_data_d;
    end
  end

endmodule

// File: tb/tb_fetch_memory_port.sv
// tb/tb_fetch_memory_port.sv - self-checking bench for fetch_memory_port
module tb_fetch_memory_port;
  import fetch_memory_port_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        address_enable = 1'b0;
  regval_t     address = '0;
  logic        flush = 1'b0;
  regval_t     data;
  logic        data_valid;
  logic        has_flushed;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        mem_waitrequest = 1'b0;
  regval_t     mem_readdata = 32'hDEAD_BEEF;
  logic        mem_readdatavalid = 1'b0;

  fetch_memory_port #(.ADDR_WIDTH(32)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .address_enable    (address_enable),
    .address           (address),
    .flush             (flush),
    .data              (data),
    .data_valid        (data_valid),
    .has_flushed       (has_flushed),
    .mem_read          (mem_read),
    .mem_address       (mem_address),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Instruction memory contents seen by the bench.
  function automatic regval_t mem_word(input regval_t a);
    regval_t w;
    w = {a[31:2], 2'b00};
    if (w == 32'h100) return 32'h1234_5678;
    return w ^ 32'h5A5A_0000;
  endfunction

  // Bus slave: fixed response delay after acceptance, stall window by cycle number.
  int      cyc_n = 0;
  int      resp_delay = 1;
  int      stall_until = -1;
  bit      pend = 1'b0;
  int      rem = 0;
  regval_t paddr = '0;

  always @(posedge clock) begin
    bit      acc;
    regval_t a;
    acc = mem_read && !mem_waitrequest;
    a   = mem_address;
    #1;
    cyc_n++;
    if (pend) rem--;
    if (acc) begin
      pend  = 1'b1;
      rem   = resp_delay - 1;
      paddr = a;
    end
    mem_readdatavalid = pend && (rem == 0);
    mem_readdata      = mem_readdatavalid ? mem_word(paddr) : 32'hDEAD_BEEF;
    if (mem_readdatavalid) pend = 1'b0;
    mem_waitrequest = (cyc_n <= stall_until);
  end

  // Per-cycle logs of DUT outputs, used by the directed literal checks.
  logic    dv_log  [0:1023];
  logic    hf_log  [0:1023];
  logic    mr_log  [0:1023];
  logic    acc_log [0:1023];
  regval_t data_log[0:1023];
  regval_t ma_log  [0:1023];

  // Read-lifecycle model: a read is live from its first request cycle until its response;
  // a flush seen while it is live makes it stale until that response returns.
  bit          req_live = 1'b0;
  bit          tainted = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clock) begin
    int k;
    k = cyc_n % 1024;
    dv_log[k]   = data_valid;
    hf_log[k]   = has_flushed;
    mr_log[k]   = mem_read;
    acc_log[k]  = mem_read && !mem_waitrequest;
    data_log[k] = data;
    ma_log[k]   = mem_address;
    if (!reset_n) begin
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_data", data, Nop);
      chk("rst_has_flushed", has_flushed, 1);
      req_live   = 1'b0;
      tainted    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("has_flushed", has_flushed, !flush && !tainted);
      if (data_valid) begin
        chk("dv_enable", address_enable, 1);
        chk("dv_no_flush", flush, 0);
        chk("dv_data", data, mem_word(address));
      end else begin
        chk("idle_data_nop", data, Nop);
      end
      if (mem_read) begin
        chk("mem_addr_aligned", {30'd0, mem_address[1:0]}, 0);
        chk("single_outstanding", pend, 0);
      end
      if (prev_stall) begin
        chk("stall_hold_read", mem_read, 1);
        chk("stall_hold_addr", mem_address, prev_addr);
      end
      prev_stall = mem_read && mem_waitrequest;
      prev_addr  = mem_address;
      if (mem_read) req_live = 1'b1;
      if (mem_readdatavalid) begin
        req_live = 1'b0;
        tainted  = 1'b0;
      end else if (req_live && flush) begin
        tainted = 1'b1;
      end
    end
  end

  function automatic int count_mr(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(mr_log[i % 1024]);
    return n;
  endfunction

  function automatic int count_dv(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(dv_log[i % 1024]);
    return n;
  endfunction

  function automatic int count_acc(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(acc_log[i % 1024]);
    return n;
  endfunction

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  // Hold current inputs until data_valid is seen (inclusive), return its cycle or -1.
  task automatic wait_dv(input int limit, output int at);
    bit hit;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      hit = data_valid;
      if (hit) at = cyc_n;
      tick();
      if (hit) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    int at;

    @(negedge clock);
    chk("reset_literal_has_flushed", has_flushed, 1);
    chk("reset_literal_data", data, 32'h0000_0013);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: zero-wait read, data two cycles after the address is presented
    s = cyc_n;
    address_enable = 1'b1;
    address = 32'h100;
    resp_delay = 1;
    wait_dv(10, at);
    chk("t1_dv_cycle", at, s + 2);
    chk("t1_data", data_log[(s + 2) % 1024], 32'h1234_5678);
    chk("t1_no_read_cycle0", mr_log[s % 1024], 0);
    chk("t1_read_cycle1", mr_log[(s + 1) % 1024], 1);
    chk("t1_read_addr", ma_log[(s + 1) % 1024], 32'h100);
    chk("t1_accepts", count_acc(s, s + 2), 1);
    address_enable = 1'b0;
    tick();

    // 2: three stall cycles on a misaligned address
    s = cyc_n;
    address_enable = 1'b1;
    address = 32'h103;
    stall_until = s + 3;
    wait_dv(12, at);
    address_enable = 1'b0;
    tick();
    chk("t2_dv_cycle", at, s + 5);
    chk("t2_read_cycles", count_mr(s, s + 6), 4);
    chk("t2_read_addr", ma_log[(s + 4) % 1024], 32'h100);
    chk("t2_accepts", count_acc(s, s + 6), 1);
    chk("t2_dv_count", count_dv(s, s + 6), 1);

    // 3: flush while waiting, stale response arrives later and is dropped
    s = cyc_n;
    address_enable = 1'b1;
    address = 32'h100;
    resp_delay = 3;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    address = 32'h200;
    wait_dv(20, at);
    address_enable = 1'b0;
    resp_delay = 1;
    tick();
    chk("t3_hf_flush", hf_log[(s + 2) % 1024], 0);
    chk("t3_hf_wait", hf_log[(s + 3) % 1024], 0);
    chk("t3_hf_response", hf_log[(s + 4) % 1024], 0);
    chk("t3_hf_after", hf_log[(s + 5) % 1024], 1);
    chk("t3_no_stale_dv", count_dv(s, s + 8), 0);
    chk("t3_dv_cycle", at, s + 9);
    chk("t3_data", data_log[(s + 9) % 1024], 32'h5A5A_0200);

    // 4: enable drops in Wait, response buffered, replayed on re-presentation
    s = cyc_n;
    address_enable = 1'b1;
    address = 32'h100;
    tick();
    tick();
    address_enable = 1'b0;
    tick();
    address_enable = 1'b1;
    address = 32'h102;
    tick();
    address = 32'h104;
    wait_dv(10, at);
    address_enable = 1'b0;
    tick();
    chk("t4_no_dv_while_disabled", dv_log[(s + 2) % 1024], 0);
    chk("t4_buf_dv", dv_log[(s + 3) % 1024], 1);
    chk("t4_buf_data", data_log[(s + 3) % 1024], 32'h1234_5678);
    chk("t4_no_read_on_hit", mr_log[(s + 3) % 1024], 0);
    chk("t4_no_read_after_hit", mr_log[(s + 4) % 1024], 0);
    chk("t4_next_read_addr", ma_log[(s + 5) % 1024], 32'h104);
    chk("t4_next_dv_cycle", at, s + 6);
    chk("t4_next_data", data_log[(s + 6) % 1024], 32'h5A5A_0104);

    // 5: flush during a stalled request, then a new read after the discard
    s = cyc_n;
    address_enable = 1'b1;
    address = 32'h300;
    stall_until = s + 3;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    address = 32'h200;
    wait_dv(15, at);
    address_enable = 1'b0;
    tick();
    chk("t5_held_reads", count_mr(s + 1, s + 4), 4);
    chk("t5_held_addr", ma_log[(s + 4) % 1024], 32'h300);
    chk("t5_no_read_discard", count_mr(s + 5, s + 6), 0);
    chk("t5_new_read", mr_log[(s + 7) % 1024], 1);
    chk("t5_new_addr", ma_log[(s + 7) % 1024], 32'h200);
    chk("t5_hf_flush", hf_log[(s + 2) % 1024], 0);
    chk("t5_hf_discard", hf_log[(s + 5) % 1024], 0);
    chk("t5_hf_after", hf_log[(s + 6) % 1024], 1);
    chk("t5_no_stale_dv", count_dv(s, s + 7), 0);
    chk("t5_dv_cycle", at, s + 8);
    chk("t5_data", data_log[(s + 8) % 1024], 32'h5A5A_0200);

    // 6: reset mid-Wait, late response after reset is ignored
    s = cyc_n;
    address_enable = 1'b1;
    address = 32'h100;
    resp_delay = 3;
    tick();
    tick();
    reset_n = 1'b0;
    address_enable = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    resp_delay = 1;
    address_enable = 1'b1;
    address = 32'h104;
    wait_dv(10, at);
    address_enable = 1'b0;
    tick();
    chk("t6_rst_read", mr_log[(s + 2) % 1024], 0);
    chk("t6_rst_hf", hf_log[(s + 2) % 1024], 1);
    chk("t6_rst_dv", dv_log[(s + 2) % 1024], 0);
    chk("t6_late_resp_no_dv", count_dv(s + 3, s + 7), 0);
    chk("t6_no_reads", count_mr(s + 3, s + 6), 0);
    chk("t6_new_read", mr_log[(s + 7) % 1024], 1);
    chk("t6_dv_cycle", at, s + 8);
    chk("t6_data", data_log[(s + 8) % 1024], 32'h5A5A_0104);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
